// File: rtl/useq_ctl_if.sv
// rtl/useq_ctl_if.sv - microsequencer control-store/datapath signal bundle
interface useq_ctl_if;
    logic [13:0] cs_next_h;
    logic        cs_jsr_h;
    logic [5:0]  cs_but_h;
    logic [7:0]  utest_h;
    logic [3:0]  disp_h;
    logic        utrap_req_h;
    logic [13:0] utrap_vec_h;
    logic        stall_h;
    logic [13:0] cs_addr_h;
    logic        dis_hi_next_h;
    logic        utrap_ack_h;
    logic        stk_ovf_h;
    logic        stk_unf_h;

    modport slave (
        input  cs_next_h, cs_jsr_h, cs_but_h, utest_h, disp_h,
        input  utrap_req_h, utrap_vec_h, stall_h,
        output cs_addr_h, dis_hi_next_h, utrap_ack_h, stk_ovf_h, stk_unf_h
    );

    modport master (
        output cs_next_h, cs_jsr_h, cs_but_h, utest_h, disp_h,
        output utrap_req_h, utrap_vec_h, stall_h,
        input  cs_addr_h, dis_hi_next_h, utrap_ack_h, stk_ovf_h, stk_unf_h
    );
endinterface

// File: rtl/useq_ctl.sv
// rtl/useq_ctl.sv - next-address sequencer with return stack and microtrap entry
module useq_ctl #(
    parameter int          STK_DEPTH = 8,
    parameter logic [13:0] RESET_VEC = 14'h0000
) (
    input  logic       m_clk_l,
    input  logic       reset_l,
    useq_ctl_if.slave  bus
);
    localparam int            PW         = $clog2(STK_DEPTH);
    localparam logic [PW:0]   DEPTH_FULL = (PW + 1)'(STK_DEPTH);

    logic [13:0]   cs_addr_q, cs_addr_d;
    logic          dis_q, dis_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   depth_q, depth_d;
    logic [13:0]   stk_q [STK_DEPTH];

    logic          take_trap, do_pop, do_push;
    logic [13:0]   top_data;
    logic [PW-1:0] ptr_pop;
    logic [PW:0]   depth_pop;
    logic          wr_en;
    logic [PW-1:0] wr_ptr;
    logic [13:0]   wr_data;

    assign take_trap = bus.utrap_req_h & ~bus.stall_h;
    assign do_pop    = ~bus.stall_h & ~bus.utrap_req_h & (bus.cs_but_h == 6'h01);
    assign do_push   = ~bus.stall_h & (bus.utrap_req_h | bus.cs_jsr_h);
    assign top_data  = (depth_q == '0) ? 14'h0000 : stk_q[ptr_q];

    // Stack update: a pop (if any) is resolved first, then a push lands on top of that.
    always_comb begin
        ptr_pop   = ptr_q;
        depth_pop = depth_q;
        unf_d     = unf_q;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        wr_ptr    = ptr_q;
        wr_data   = 14'h0000;
        if (do_pop) begin
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                ptr_pop   = ptr_q - 1'b1;
                depth_pop = depth_q - 1'b1;
            end
        end
        ptr_d   = ptr_pop;
        depth_d = depth_pop;
        if (do_push) begin
            ptr_d   = ptr_pop + 1'b1;
            wr_en   = 1'b1;
            wr_ptr  = ptr_pop + 1'b1;
            // A trap saves the aborted word itself so it re-executes on return.
            wr_data = bus.utrap_req_h ? cs_addr_q : cs_addr_q + 14'd1;
            if (depth_pop == DEPTH_FULL) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_pop + 1'b1;
            end
        end
    end

    always_comb begin
        cs_addr_d = cs_addr_q;
        dis_d     = dis_q;
        if (!bus.stall_h) begin
            dis_d = 1'b0;
            if (bus.utrap_req_h) begin
                cs_addr_d = bus.utrap_vec_h;
                dis_d     = 1'b1;
            end else if (bus.cs_but_h == 6'h01) begin
                cs_addr_d = top_data;
                dis_d     = 1'b1;
            end else if (bus.cs_but_h[5:3] == 3'b010) begin
                cs_addr_d = {bus.cs_next_h[13:1],
                             bus.cs_next_h[0] | bus.utest_h[bus.cs_but_h[2:0]]};
            end else if (bus.cs_but_h == 6'h20) begin
                cs_addr_d = {bus.cs_next_h[13:2], bus.cs_next_h[1:0] | bus.disp_h[1:0]};
            end else if (bus.cs_but_h == 6'h21) begin
                cs_addr_d = {bus.cs_next_h[13:4], bus.cs_next_h[3:0] | bus.disp_h};
            end else begin
                cs_addr_d = bus.cs_next_h;
            end
        end
    end

    always_ff @(posedge m_clk_l or negedge reset_l) begin
        if (!reset_l) begin
            cs_addr_q <= RESET_VEC;
            dis_q     <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ptr_q     <= '0;
            depth_q   <= '0;
        end else begin
            cs_addr_q <= cs_addr_d;
            dis_q     <= dis_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ptr_q     <= ptr_d;
            depth_q   <= depth_d;
        end
    end

    // Stack contents are not reset; depth alone decides what is valid.
    always_ff @(posedge m_clk_l) begin
        if (wr_en) begin
            stk_q[wr_ptr] <= wr_data;
        end
    end

    assign bus.cs_addr_h     = cs_addr_q;
    assign bus.dis_hi_next_h = dis_q;
    assign bus.utrap_ack_h   = take_trap;
    assign bus.stk_ovf_h     = ovf_q;
    assign bus.stk_unf_h     = unf_q;
endmodule

// File: tb/tb_useq_ctl.sv
// tb/tb_useq_ctl.sv - scoreboard bench for useq_ctl against a queue-based stack model
module tb_useq_ctl;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    useq_ctl_if bus ();

    useq_ctl #(.STK_DEPTH(DEPTH), .RESET_VEC(14'h0000)) dut (
        .m_clk_l (clk),
        .reset_l (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] addr;
        logic        dis;
        logic        ovf;
        logic        unf;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [13:0] m_addr;
    logic        m_dis, m_ovf, m_unf;
    logic [13:0] m_stk[$];

    function automatic void m_push(input logic [13:0] v);
        if (m_stk.size() == DEPTH) begin
            m_ovf = 1'b1;
            void'(m_stk.pop_front());
        end
        m_stk.push_back(v);
    endfunction

    function automatic logic [13:0] m_pop();
        if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            return 14'h0000;
        end
        return m_stk.pop_back();
    endfunction

    task automatic step(input logic rst, input logic [13:0] cn, input logic jsr,
                        input logic [5:0] but, input logic [7:0] ut, input logic [3:0] dsp,
                        input logic req, input logic [13:0] vec, input logic stl);
        exp_t        e;
        logic [13:0] nxt;
        int          b;
        @(posedge clk);
        #1;
        bus.cs_next_h   = cn;
        bus.cs_jsr_h    = jsr;
        bus.cs_but_h    = but;
        bus.utest_h     = ut;
        bus.disp_h      = dsp;
        bus.utrap_req_h = req;
        bus.utrap_vec_h = vec;
        bus.stall_h     = stl;
        if (rst) begin
            rst_n  = 1'b0;
            m_addr = 14'h0000;
            m_dis  = 1'b1;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_stk.delete();
        end else begin
            rst_n = 1'b1;
        end
        e.addr = m_addr;
        e.dis  = m_dis;
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        e.ack  = req & ~stl;
        exp_q.push_back(e);
        if (!rst && !stl) begin
            if (req) begin
                m_push(m_addr);
                nxt   = vec;
                m_dis = 1'b1;
            end else begin
                if (but == 6'h01) begin
                    nxt   = m_pop();
                    m_dis = 1'b1;
                end else begin
                    nxt = cn;
                    if (but >= 6'h10 && but <= 6'h17) begin
                        b = int'(but) - 16;
                        if (((ut >> b) & 8'h01) != 0) nxt = cn | 14'h0001;
                    end else if (but == 6'h20) begin
                        nxt = cn | 14'(dsp % 4);
                    end else if (but == 6'h21) begin
                        nxt = cn | 14'(dsp);
                    end
                    m_dis = 1'b0;
                end
                if (jsr) m_push(14'((int'(m_addr) + 1) % 16384));
            end
            m_addr = nxt;
        end
    endtask

    task automatic go(input logic [13:0] cn, input logic jsr, input logic [5:0] but);
        step(1'b0, cn, jsr, but, 8'h00, 4'h0, 1'b0, 14'h0000, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.cs_addr_h !== e.addr) begin
                n_err++;
                $display("FAIL cs_addr got=%h exp=%h t=%0t", bus.cs_addr_h, e.addr, $time);
            end
            if (bus.dis_hi_next_h !== e.dis) begin
                n_err++;
                $display("FAIL dis_hi got=%b exp=%b t=%0t", bus.dis_hi_next_h, e.dis, $time);
            end
            if (bus.stk_ovf_h !== e.ovf) begin
                n_err++;
                $display("FAIL stk_ovf got=%b exp=%b t=%0t", bus.stk_ovf_h, e.ovf, $time);
            end
            if (bus.stk_unf_h !== e.unf) begin
                n_err++;
                $display("FAIL stk_unf got=%b exp=%b t=%0t", bus.stk_unf_h, e.unf, $time);
            end
            if (bus.utrap_ack_h !== e.ack) begin
                n_err++;
                $display("FAIL utrap_ack got=%b exp=%b t=%0t", bus.utrap_ack_h, e.ack, $time);
            end
        end
    end

    initial begin
        logic [13:0] a;
        int          r;
        rst_n = 1'b0;
        bus.cs_next_h = '0; bus.cs_jsr_h = 1'b0; bus.cs_but_h = '0; bus.utest_h = '0;
        bus.disp_h = '0; bus.utrap_req_h = 1'b0; bus.utrap_vec_h = '0; bus.stall_h = 1'b0;
        repeat (3) step(1'b1, 14'h0, 1'b0, 6'h0, 8'h0, 4'h0, 1'b0, 14'h0, 1'b0);

        go(14'h0123, 1'b0, 6'h00);
        go(14'h0040, 1'b0, 6'h00);
        step(1'b0, 14'h0200, 1'b0, 6'h13, 8'h08, 4'h0, 1'b0, 14'h0, 1'b0);
        go(14'h0040, 1'b0, 6'h00);
        step(1'b0, 14'h0200, 1'b0, 6'h13, 8'h00, 4'h0, 1'b0, 14'h0, 1'b0);
        step(1'b0, 14'h0300, 1'b0, 6'h21, 8'h00, 4'hA, 1'b0, 14'h0, 1'b0);
        step(1'b0, 14'h0300, 1'b0, 6'h20, 8'h00, 4'hF, 1'b0, 14'h0, 1'b0);

        go(14'h0050, 1'b0, 6'h00);
        go(14'h1000, 1'b1, 6'h00);
        go(14'h0000, 1'b0, 6'h01);
        for (int i = 0; i < 3; i++) go(14'h0800 + 14'(i * 16), 1'b1, 6'h00);
        for (int i = 0; i < 3; i++) go(14'h0000, 1'b0, 6'h01);
        go(14'h0A00, 1'b1, 6'h01);
        go(14'h0000, 1'b0, 6'h01);

        for (int i = 0; i < 9; i++) go(14'h0100 + 14'(i * 32), 1'b1, 6'h00);
        for (int i = 0; i < 9; i++) go(14'h0000, 1'b0, 6'h01);

        go(14'h3FFF, 1'b0, 6'h00);
        go(14'h0123, 1'b1, 6'h00);
        go(14'h0000, 1'b0, 6'h01);

        go(14'h0077, 1'b0, 6'h00);
        step(1'b0, 14'h0200, 1'b1, 6'h13, 8'hFF, 4'h0, 1'b1, 14'h1F00, 1'b0);
        go(14'h0000, 1'b0, 6'h01);

        go(14'h0055, 1'b1, 6'h00);
        repeat (3) step(1'b0, 14'h0300, 1'b1, 6'h01, 8'h00, 4'h0, 1'b1, 14'h1E00, 1'b1);
        step(1'b0, 14'h0300, 1'b1, 6'h01, 8'h00, 4'h0, 1'b1, 14'h1E00, 1'b0);
        go(14'h0000, 1'b0, 6'h01);
        go(14'h0000, 1'b0, 6'h01);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    a = {8'h00, 6'h01};
                2, 3:    a = {8'h00, 3'b010, 3'($urandom_range(0, 7))};
                4:       a = {8'h00, 6'h20};
                5:       a = {8'h00, 6'h21};
                6:       a = {8'h00, 6'($urandom_range(0, 63))};
                default: a = 14'h0000;
            endcase
            if (i == 1500) begin
                step(1'b1, 14'h0, 1'b0, 6'h0, 8'h0, 4'h0, 1'b0, 14'h0, 1'b0);
            end else begin
                step(1'b0, 14'($urandom_range(0, 16383)), ($urandom_range(0, 3) == 0),
                     a[5:0], 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 19) == 0), 14'($urandom_range(0, 16383)),
                     ($urandom_range(0, 6) == 0));
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
